// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_stream_ctrl: debounced button -> message TX, RX FIFO echo/drain,      |
// | byte-boundary TX arbitration, saturating overflow count.                   |
// | Optional: UART_ECHO_UPCASE_EN upper-cases a..z at FIFO push.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_stream_ctrl #(
    parameter int FIFO_DEPTH      = 16,
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int MSG_LEN         = 11,
    parameter int DROP_CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_n,
    input  logic                          echo_en,
    input  logic [7:0]                    rx_word,
    input  logic                          rx_rxne,
    input  logic                          rx_ore,
    output logic                          rx_rxne_clear,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_busy,
    output logic                          msg_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = $clog2(MSG_LEN + 1);
    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(MSG_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] rom_byte(input logic [c_IDX_W-1:0] idx);
        int unsigned i;
        i = 32'(idx);
        if (i < 32'(MSG_LEN - 1)) return 8'(32'h30 + i % 10);
        return 8'h0A;
    endfunction

    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  btn_pressed_q, btn_pressed_d, press_q, press_d;
    logic [c_DB_W-1:0]     db_cnt_q, db_cnt_d;
    state_t                state_q, state_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  cur_msg_q, cur_msg_d;
    logic                  msg_busy_q, msg_busy_d;
    logic [c_IDX_W-1:0]    msg_idx_q, msg_idx_d;
    logic                  rx_clear_q, rx_clear_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [7:0]            mem_q [FIFO_DEPTH];

    logic                  w_full, w_empty, w_accept, w_push, w_pop, w_pop_echo;
    logic                  w_tx_valid;
    logic [7:0]            w_push_byte;
    logic [DROP_CNT_W+1:0] w_drop_sum;

`ifdef UART_ECHO_UPCASE_EN
    always_comb begin
        w_push_byte = rx_word;
        if (rx_word >= 8'h61 && rx_word <= 8'h7A) w_push_byte = rx_word - 8'h20;
    end
`else
    assign w_push_byte = rx_word;
`endif

    // Filtered state flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        sync1_d       = btn_n;
        sync2_d       = sync1_q;
        db_cnt_d      = '0;
        btn_pressed_d = btn_pressed_q;
        press_d       = 1'b0;
        if ((~sync2_q) != btn_pressed_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                btn_pressed_d = ~btn_pressed_q;
                press_d       = ~btn_pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + c_DB_W'(1);
            end
        end
    end

    always_comb begin
        w_full     = (count_q == c_FULL);
        w_empty    = (count_q == '0);
        w_accept   = rx_rxne & ~rx_clear_q;
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        cur_msg_d  = cur_msg_q;
        msg_busy_d = msg_busy_q;
        msg_idx_d  = msg_idx_q;
        w_tx_valid = 1'b0;
        w_pop_echo = 1'b0;
        case (state_q)
            // A new byte is only taken once the core is idle, so nothing is
            // pulled out of the FIFO while the line is held busy.
            S_IDLE: begin
                if (!tx_busy) begin
                    if (msg_busy_q) begin
                        tx_data_d = rom_byte(msg_idx_q);
                        cur_msg_d = 1'b1;
                        state_d   = S_ISSUE;
                    end else if (echo_en && !w_empty) begin
                        tx_data_d  = mem_q[rd_ptr_q];
                        cur_msg_d  = 1'b0;
                        w_pop_echo = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!tx_busy) begin
                    w_tx_valid = 1'b1;
                    state_d    = S_WAIT_ACK;
                    if (cur_msg_q && msg_idx_q == c_IDX_LAST) begin
                        msg_busy_d = 1'b0;
                        cur_msg_d  = 1'b0;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                    if (cur_msg_q) msg_idx_d = msg_idx_q + c_IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (press_q && !msg_busy_q) begin
            msg_busy_d = 1'b1;
            msg_idx_d  = '0;
        end

        w_pop      = w_pop_echo | (~echo_en & ~w_empty);
        w_push     = w_accept & (~w_full | w_pop);
        rx_clear_d = w_accept;
        wr_ptr_d   = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A full-FIFO drop and an overrun can land in the same cycle.
        w_drop_sum = (DROP_CNT_W+2)'(drop_q)
                   + (DROP_CNT_W+2)'(w_accept & w_full & ~w_pop)
                   + (DROP_CNT_W+2)'(rx_ore);
        drop_d = (w_drop_sum[DROP_CNT_W+1:DROP_CNT_W] != 2'b00) ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            btn_pressed_q <= 1'b0;
            press_q       <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= S_IDLE;
            tx_data_q     <= 8'h00;
            cur_msg_q     <= 1'b0;
            msg_busy_q    <= 1'b0;
            msg_idx_q     <= '0;
            rx_clear_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drop_q        <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_pressed_q <= btn_pressed_d;
            press_q       <= press_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            cur_msg_q     <= cur_msg_d;
            msg_busy_q    <= msg_busy_d;
            msg_idx_q     <= msg_idx_d;
            rx_clear_q    <= rx_clear_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= w_push_byte;
    end

    assign rx_rxne_clear = rx_clear_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = w_tx_valid;
    assign msg_busy      = msg_busy_q;
    assign fifo_count    = count_q;
    assign drop_cnt      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_stream_ctrl: self-checking bench with a simple UART core model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_stream_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int DEB        = 5;
    localparam int MSG_LEN    = 11;
    localparam int DW         = 8;

    logic       clk = 1'b0, rst = 1'b1, btn_n = 1'b1, echo_en = 1'b0;
    logic [7:0] rx_word = 8'h00;
    logic       rx_rxne = 1'b0, rx_ore = 1'b0;
    logic       rx_rxne_clear, tx_valid, tx_busy, msg_busy;
    logic [7:0] tx_data;
    logic [2:0] fifo_count;
    logic [7:0] drop_cnt;

    int checks = 0, passes = 0;
    int busy_len = 10, busy_cnt = 0, hold_err = 0, clr_cnt = 0;
    logic hold_busy = 1'b0, hold_chk = 1'b0;
    logic [7:0] hold_byte = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] exp_plain;
        logic [7:0] exp_up;
    } vec_t;
    vec_t tbl[8];

    uart_stream_ctrl #(
        .FIFO_DEPTH(FIFO_DEPTH), .DEBOUNCE_CYCLES(DEB),
        .MSG_LEN(MSG_LEN), .DROP_CNT_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .echo_en(echo_en),
        .rx_word(rx_word), .rx_rxne(rx_rxne), .rx_ore(rx_ore),
        .rx_rxne_clear(rx_rxne_clear), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_busy(tx_busy), .msg_busy(msg_busy), .fifo_count(fifo_count),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // UART core model: busy for busy_len cycles after each strobe.
    assign tx_busy = hold_busy | (busy_cnt != 0);
    always @(posedge clk) begin
        if (rx_rxne_clear) clr_cnt <= clr_cnt + 1;
        if (rst) hold_chk <= 1'b0;
        if (tx_valid === 1'b1) begin
            got_q.push_back(tx_data);
            busy_cnt  <= busy_len;
            hold_byte <= tx_data;
            hold_chk  <= 1'b1;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (hold_chk && busy_cnt > 0 && !rst && tx_data != hold_byte) hold_err <= hold_err + 1;
        end
    end

    function automatic logic [7:0] msg_byte(input int i);
        if (i < MSG_LEN - 1) return 8'(8'h30 + i % 10);
        return 8'h0A;
    endfunction

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bit seen = 0;
        rx_word = b;
        rx_rxne = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (rx_rxne_clear) seen = 1;
        end
        rx_rxne = 1'b0;
        if (!seen) check("rx_clear_timeout", 0, 1);
    endtask

    task automatic wait_strobes(input int n, input int limit, input string name);
        for (int k = 0; k < limit && got_q.size() < n; k++) tick();
        check(name, got_q.size() >= n, 1);
    endtask

    task automatic press_until_busy(input string name);
        btn_n = 1'b0;
        for (int k = 0; k < 30 && !msg_busy; k++) tick();
        check(name, msg_busy, 1);
        btn_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_clear"}, rx_rxne_clear, 0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_msg_busy"}, msg_busy, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, c0, exp_drop, idx;
        bit seen, found;
        logic [7:0] b;

        tbl[0] = '{8'h41, 8'h41, 8'h41};
        tbl[1] = '{8'h62, 8'h62, 8'h42};
        tbl[2] = '{8'h0D, 8'h0D, 8'h0D};
        tbl[3] = '{8'h61, 8'h61, 8'h41};
        tbl[4] = '{8'h7A, 8'h7A, 8'h5A};
        tbl[5] = '{8'h7B, 8'h7B, 8'h7B};
        tbl[6] = '{8'h60, 8'h60, 8'h60};
        tbl[7] = '{8'h40, 8'h40, 8'h40};

        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Short press and 1-cycle glitches must not start a message.
        btn_n = 1'b0; tick(4); btn_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (msg_busy) seen = 1; end
        check("short_press", seen, 0);
        for (int k = 0; k < 6; k++) begin btn_n = 1'b0; tick(); btn_n = 1'b1; tick(); end
        for (int k = 0; k < 15; k++) begin tick(); if (msg_busy) seen = 1; end
        check("glitch_press", seen, 0);

        // Full press: msg_busy rises 2 + DEB + 1 cycles after btn_n falls.
        got_q.delete();
        btn_n = 1'b0;
        lat = 0;
        while (lat < 30 && !msg_busy) begin tick(); lat++; end
        check("press_latency", lat, DEB + 3);
        btn_n = 1'b1;
        tick(30);
        btn_n = 1'b0; tick(10); btn_n = 1'b1;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (tx_valid && got_q.size() == MSG_LEN - 1) begin
                check("busy_at_last", msg_busy, 1);
                tick();
                check("busy_after_last", msg_busy, 0);
                found = 1;
            end
        end
        check("msg_last_found", found, 1);
        tick(2);
        check("msg_len", got_q.size(), MSG_LEN);
        for (int i = 0; i < MSG_LEN && i < got_q.size(); i++) check("msg_byte", got_q[i], msg_byte(i));
        tick(200);
        check("second_press_ignored", got_q.size(), MSG_LEN);

        // Table-driven echo.
        echo_en = 1'b1;
        busy_len = 4;
        c0 = clr_cnt;
        foreach (tbl[i]) begin
            got_q.delete();
            send_rx(tbl[i].rx);
            wait_strobes(1, 100, "echo_wait");
`ifdef UART_ECHO_UPCASE_EN
            if (got_q.size() > 0) check("echo_tbl", got_q[0], tbl[i].exp_up);
`else
            if (got_q.size() > 0) check("echo_tbl", got_q[0], tbl[i].exp_plain);
`endif
        end
        tick(10);
        check("rx_clear_pulses", clr_cnt - c0, 8);

        // Overflow with the line held busy.
        tick(30);
        got_q.delete();
        hold_busy = 1'b1;
        check("drop_before_ovf", drop_cnt, 0);
        for (int i = 0; i < 6; i++) send_rx(8'(8'h11 + i));
        tick(2);
        check("ovf_fifo_count", fifo_count, FIFO_DEPTH);
        check("ovf_drop_cnt", drop_cnt, 2);
        hold_busy = 1'b0;
        wait_strobes(4, 200, "ovf_drain_wait");
        tick(60);
        check("ovf_echo_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("ovf_echo_byte", got_q[i], 8'(8'h11 + i));
        check("ovf_fifo_empty", fifo_count, 0);

        // Echo in flight + 3 queued, then a press: in-flight, message, queued.
        got_q.delete();
        busy_len = 10;
        send_rx(8'hA1);
        wait_strobes(1, 50, "inflight_wait");
        hold_busy = 1'b1;
        send_rx(8'hB1); send_rx(8'hB2); send_rx(8'hB3);
        check("queued_count", fifo_count, 3);
        press_until_busy("arb_press");
        hold_busy = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'hA1);
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(msg_byte(i));
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
        wait_strobes(exp_q.size(), 800, "arb_wait");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("arb_order", got_q[i], exp_q[i]);

        // Drain with echo disabled.
        tick(30);
        got_q.delete();
        hold_busy = 1'b1;
        send_rx(8'hC1); send_rx(8'hC2); send_rx(8'hC3);
        check("drain_start", fifo_count, 3);
        echo_en = 1'b0;
        tick(2);
        check("drain_2", fifo_count, 1);
        tick(1);
        check("drain_3", fifo_count, 0);
        hold_busy = 1'b0;
        tick(40);
        check("drain_no_tx", got_q.size(), 0);
        echo_en = 1'b1;

        // Reset during message byte 5, then restart.
        tick(20);
        got_q.delete();
        press_until_busy("rst_press");
        wait_strobes(5, 300, "rst_wait5");
        tick(3);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        got_q.delete();
        tick(30);
        check("midrst_quiet", got_q.size(), 0);
        press_until_busy("restart_press");
        wait_strobes(1, 100, "restart_wait");
        if (got_q.size() > 0) check("restart_first", got_q[0], 8'h30);
        for (int k = 0; k < 400 && msg_busy; k++) tick();
        tick(20);
        check("restart_len", got_q.size(), MSG_LEN);
        if (got_q.size() > 0) check("restart_last", got_q[got_q.size()-1], 8'h0A);

        // Randomised bursts and overrun pulses against the queue model.
        exp_drop = 0;
        for (int it = 0; it < 25; it++) begin
            int burst;
            burst = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 12);
            got_q.delete();
            exp_q.delete();
            for (int j = 0; j < burst; j++) begin
                b = 8'($urandom);
                exp_q.push_back(echo_of(b));
                send_rx(b);
                if ($urandom_range(0, 3) == 0) begin
                    rx_ore = 1'b1; tick(); rx_ore = 1'b0;
                    exp_drop++;
                end
            end
            wait_strobes(exp_q.size(), 300, "rand_wait");
            tick(20);
            check("rand_count", got_q.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) check("rand_byte", got_q[j], exp_q[j]);
        end
        idx = (exp_drop > 255) ? 255 : exp_drop;
        check("rand_drop_cnt", drop_cnt, idx);

        // Saturation of the drop counter.
        rx_ore = 1'b1; tick(300); rx_ore = 1'b0; tick();
        check("drop_saturate", drop_cnt, 8'hFF);

        check("tx_data_hold", hold_err, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
